rotary_decoder: RTL and testbench

Quadrature decoder for the panel rotary encoder: synchronizes and debounces the raw A/B contacts, tracks the Gray-code sequence, and emits one `step` pulse per detent with a registered `dir` and a wrapping position count. It sits between the encoder pins and the runlight logic, which consumes `dir` and `step`.

---
 rtl/rotary_decoder.sv | 236 +++++++++++++++++++++++
 tb/tb_rotary_decoder.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/rotary_decoder.sv
// Panel rotary encoder front end: two-flop sync, per-channel debounce,
// Gray-code quarter tracking, one step pulse per detent and a wrapping count.

module rotary_sync_stage (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] raw_i,
    output logic [1:0] sync_o
);

    logic [1:0] s1_q;
    logic [1:0] s2_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= 2'b11;
            s2_q <= 2'b11;
        end else begin
            s1_q <= raw_i;
            s2_q <= s1_q;
        end
    end

    assign sync_o = s2_q;

endmodule

module rotary_debounce_stage #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic in_i,
    output logic deb_o
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          deb_q;
    logic          deb_d;

    // Accept on the clock the count would reach DEBOUNCE_CYCLES.
    always_comb begin
        cnt_d = cnt_q;
        deb_d = deb_q;
        if (in_i == deb_q) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            deb_d = in_i;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            deb_q <= 1'b1;
        end else begin
            cnt_q <= cnt_d;
            deb_q <= deb_d;
        end
    end

    assign deb_o = deb_q;

endmodule

module rotary_quad_stage #(
    parameter int POS_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           cur_i,
    output logic                 step_o,
    output logic                 dir_o,
    output logic [POS_WIDTH-1:0] pos_o,
    output logic                 err_o
);

    localparam logic [3:0] Q_POS4 = 4'b0100;
    localparam logic [3:0] Q_NEG4 = 4'b1100;

    logic [1:0]           prev_q;
    logic [2:0]           q_q;
    logic [2:0]           q_d;
    logic                 step_q;
    logic                 step_d;
    logic                 err_q;
    logic                 err_d;
    logic                 dir_q;
    logic                 dir_d;
    logic [POS_WIDTH-1:0] pos_q;
    logic [POS_WIDTH-1:0] pos_d;

    logic       illegal;
    logic       cw;
    logic       ccw;
    logic [3:0] q_ext;
    logic [3:0] q_next;

    function automatic logic [1:0] cw_succ(input logic [1:0] s);
        logic [1:0] r;
        r = 2'b11;
        unique case (s)
            2'b11:   r = 2'b10;
            2'b10:   r = 2'b00;
            2'b00:   r = 2'b01;
            default: r = 2'b11;
        endcase
        return r;
    endfunction

    assign illegal = (cur_i == ~prev_q);
    assign cw      = (cur_i == cw_succ(prev_q));
    assign ccw     = (prev_q == cw_succ(cur_i));
    assign q_ext   = {q_q[2], q_q};
    assign q_next  = cw ? q_ext + 4'd1 : q_ext - 4'd1;

    // Only a full four-quarter run ending on the detent level counts.
    always_comb begin
        q_d    = q_q;
        step_d = 1'b0;
        err_d  = 1'b0;
        dir_d  = dir_q;
        pos_d  = pos_q;
        unique case (1'b1)
            illegal: begin
                err_d = 1'b1;
                q_d   = '0;
            end
            cw, ccw: begin
                if (cur_i == 2'b11) begin
                    q_d = '0;
                    if (q_next == Q_POS4) begin
                        step_d = 1'b1;
                        dir_d  = 1'b1;
                        pos_d  = pos_q + 1'b1;
                    end else if (q_next == Q_NEG4) begin
                        step_d = 1'b1;
                        dir_d  = 1'b0;
                        pos_d  = pos_q - 1'b1;
                    end
                end else begin
                    q_d = q_next[2:0];
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q <= 2'b11;
            q_q    <= '0;
            step_q <= 1'b0;
            err_q  <= 1'b0;
            dir_q  <= 1'b0;
            pos_q  <= '0;
        end else begin
            prev_q <= cur_i;
            q_q    <= q_d;
            step_q <= step_d;
            err_q  <= err_d;
            dir_q  <= dir_d;
            pos_q  <= pos_d;
        end
    end

    assign step_o = step_q;
    assign err_o  = err_q;
    assign dir_o  = dir_q;
    assign pos_o  = pos_q;

endmodule

module rotary_decoder #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int POS_WIDTH       = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rot_a,
    input  logic                 rot_b,
    output logic                 step,
    output logic                 dir,
    output logic [POS_WIDTH-1:0] position,
    output logic                 err
);

    logic [1:0] sync_ab;
    logic [1:0] deb_ab;

    rotary_sync_stage u_sync (
        .clk    (clk),
        .rst    (rst),
        .raw_i  ({rot_a, rot_b}),
        .sync_o (sync_ab)
    );

    rotary_debounce_stage #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_deb_a (
        .clk   (clk),
        .rst   (rst),
        .in_i  (sync_ab[1]),
        .deb_o (deb_ab[1])
    );

    rotary_debounce_stage #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_deb_b (
        .clk   (clk),
        .rst   (rst),
        .in_i  (sync_ab[0]),
        .deb_o (deb_ab[0])
    );

    rotary_quad_stage #(
        .POS_WIDTH (POS_WIDTH)
    ) u_quad (
        .clk    (clk),
        .rst    (rst),
        .cur_i  (deb_ab),
        .step_o (step),
        .dir_o  (dir),
        .pos_o  (position),
        .err_o  (err)
    );

endmodule

// File: tb/tb_rotary_decoder.sv
// Bench for rotary_decoder: pin-level vector table with an event
// scoreboard checking step/err pulses, their latency, dir and position.

module tb_rotary_decoder;

    localparam int DEB = 4;
    localparam int PW  = 8;
    localparam int HOLD = 20;

    logic          clk;
    logic          rst;
    logic          rot_a;
    logic          rot_b;
    logic          step;
    logic          dir;
    logic [PW-1:0] position;
    logic          err;

    rotary_decoder #(
        .DEBOUNCE_CYCLES (DEB),
        .POS_WIDTH       (PW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rot_a    (rot_a),
        .rot_b    (rot_b),
        .step     (step),
        .dir      (dir),
        .position (position),
        .err      (err)
    );

    typedef struct {
        logic [1:0]    pins;
        logic          ev_step;
        logic          ev_err;
        logic          dir;
        logic [PW-1:0] pos;
    } vec_t;

    typedef struct {
        logic          is_err;
        logic          dir;
        logic [PW-1:0] pos;
        int            due;
    } ev_t;

    vec_t tbl[$];
    ev_t  sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Each observed pulse must match the oldest expected event.
    always @(negedge clk) begin
        if (step || err) begin
            check("step_err_exclusive", 32'(step & err), 32'd0);
            if (sb.size() == 0) begin
                check("unexpected_pulse", 32'({step, err}), 32'd0);
            end else begin
                ev_t e;
                e = sb.pop_front();
                check("pulse_kind_err", 32'(err), 32'(e.is_err));
                check("pulse_dir", 32'(dir), 32'(e.dir));
                check("pulse_pos", 32'(position), 32'(e.pos));
                check("pulse_latency", 32'(cyc), 32'(e.due));
            end
        end
    end

    task automatic add(input logic [1:0] p, input logic s, input logic e,
                       input logic d, input logic [PW-1:0] pos);
        vec_t v;
        v.pins    = p;
        v.ev_step = s;
        v.ev_err  = e;
        v.dir     = d;
        v.pos     = pos;
        tbl.push_back(v);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        @(negedge clk);
        rot_a = v.pins[1];
        rot_b = v.pins[0];
        if (v.ev_step || v.ev_err) begin
            ev_t e;
            e.is_err = v.ev_err;
            e.dir    = v.dir;
            e.pos    = v.pos;
            e.due    = cyc + DEB + 3;
            sb.push_back(e);
        end
        repeat (HOLD) @(negedge clk);
        check({tag, "_dir"}, 32'(dir), 32'(v.dir));
        check({tag, "_pos"}, 32'(position), 32'(v.pos));
        check({tag, "_sb_drained"}, 32'(sb.size()), 32'd0);
    endtask

    task automatic add_cw(input logic d0, input logic [PW-1:0] p0,
                          input logic [PW-1:0] p1);
        add(2'b10, 0, 0, d0, p0);
        add(2'b00, 0, 0, d0, p0);
        add(2'b01, 0, 0, d0, p0);
        add(2'b11, 1, 0, 1'b1, p1);
    endtask

    task automatic add_ccw(input logic d0, input logic [PW-1:0] p0,
                           input logic [PW-1:0] p1);
        add(2'b01, 0, 0, d0, p0);
        add(2'b00, 0, 0, d0, p0);
        add(2'b10, 0, 0, d0, p0);
        add(2'b11, 1, 0, 1'b0, p1);
    endtask

    initial begin
        vec_t v;
        rst   = 1'b1;
        rot_a = 1'b1;
        rot_b = 1'b1;

        repeat (3) @(negedge clk);
        check("reset_step", 32'(step), 32'd0);
        check("reset_err", 32'(err), 32'd0);
        check("reset_dir", 32'(dir), 32'd0);
        check("reset_pos", 32'(position), 32'd0);
        rst = 1'b0;
        repeat (50) @(negedge clk);
        check("idle_pos", 32'(position), 32'd0);
        check("idle_dir", 32'(dir), 32'd0);

        @(negedge clk);
        rot_a = 1'b0;
        repeat (2) @(negedge clk);
        rot_a = 1'b1;
        repeat (HOLD) @(negedge clk);
        check("glitch_pos", 32'(position), 32'd0);
        check("glitch_dir", 32'(dir), 32'd0);

        add_cw(1'b0, 8'd0, 8'd1);
        add_ccw(1'b1, 8'd1, 8'd0);
        add_ccw(1'b0, 8'd0, 8'd255);
        add_ccw(1'b0, 8'd255, 8'd254);
        add_ccw(1'b0, 8'd254, 8'd253);
        add(2'b10, 0, 0, 1'b0, 8'd253);
        add(2'b00, 0, 0, 1'b0, 8'd253);
        add(2'b10, 0, 0, 1'b0, 8'd253);
        add(2'b11, 0, 0, 1'b0, 8'd253);
        add(2'b00, 0, 1, 1'b0, 8'd253);
        add(2'b01, 0, 0, 1'b0, 8'd253);
        add(2'b11, 0, 0, 1'b0, 8'd253);
        add_cw(1'b0, 8'd253, 8'd254);

        for (int i = 0; i < tbl.size(); i++) begin
            run_vec(tbl[i], $sformatf("vec%0d", i));
        end

        v = '{2'b10, 1'b0, 1'b0, 1'b1, 8'd254};
        run_vec(v, "mid_q1");
        v = '{2'b00, 1'b0, 1'b0, 1'b1, 8'd254};
        run_vec(v, "mid_q2");
        #2 rst = 1'b1;
        #1;
        check("async_rst_step", 32'(step), 32'd0);
        check("async_rst_err", 32'(err), 32'd0);
        check("async_rst_dir", 32'(dir), 32'd0);
        check("async_rst_pos", 32'(position), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        begin
            ev_t e;
            e.is_err = 1'b1;
            e.dir    = 1'b0;
            e.pos    = '0;
            e.due    = cyc + DEB + 3;
            sb.push_back(e);
        end
        repeat (HOLD) @(negedge clk);
        check("post_rst_sb_drained", 32'(sb.size()), 32'd0);
        v = '{2'b01, 1'b0, 1'b0, 1'b0, 8'd0};
        run_vec(v, "post_rst_q3");
        v = '{2'b11, 1'b0, 1'b0, 1'b0, 8'd0};
        run_vec(v, "post_rst_q4");
        tbl.delete();
        add_cw(1'b0, 8'd0, 8'd1);
        for (int i = 0; i < tbl.size(); i++) begin
            run_vec(tbl[i], $sformatf("fresh%0d", i));
        end

        repeat (HOLD) @(negedge clk);
        check("final_sb_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
